systolic_feeder: RTL and testbench

//   Transmit side of the systolic array's west/north data interface. Accepts K
//   row-vectors of A and column-vectors of B over a valid/ready stream and skews

---
 rtl/feeder_pkg.sv | 18 +
 rtl/skew_delay_line.sv | 34 +++
 rtl/systolic_feeder.sv | 160 ++++++++++++++++
 tb/tb_systolic_feeder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared definitions for the systolic array operand feeder: FSM state encoding
// and the flush length needed to drain a skewed vector past the far PE.
package feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_e;

    // The deepest lane lags by max(H,W); H+W-1 zero cycles cover the
    // diagonal wavefront reaching PE (H-1, W-1).
    function automatic int flush_cycles(input int arr_height, input int arr_width);
        return arr_height + arr_width - 1;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Per-lane shift register used to skew operands diagonally; DEPTH=0 collapses
// to a plain wire.
module skew_delay_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] sr_p0 [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < DEPTH; k++) sr_p0[k] <= '0;
                end else begin
                    sr_p0[0] <= din;
                    for (int k = 1; k < DEPTH; k++) sr_p0[k] <= sr_p0[k-1];
                end
            end

            assign dout = sr_p0[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Transmit side of the systolic array west/north interface: accepts K operand
// vectors, skews lane i by 1+i cycles, flushes with zeros, then pulses done.
// Optional feature macro FEEDER_BUBBLE_EN: s_valid low in FEED inserts a zero
// bubble instead of aborting the job with err.
module systolic_feeder
    import feeder_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ARR_HEIGHT = 4,
    parameter int ARR_WIDTH  = 4,
    parameter int K_MAX      = 256,
    parameter int CNT_W      = $clog2(K_MAX + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [CNT_W-1:0]            cfg_k,
    input  logic [1:0]                  cfg_simd,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [ARR_HEIGHT*WIDTH-1:0] s_a,
    input  logic [ARR_WIDTH*WIDTH-1:0]  s_b,
    output logic [ARR_HEIGHT*WIDTH-1:0] out_a,
    output logic [ARR_WIDTH*WIDTH-1:0]  out_b,
    output logic [1:0]                  SIMD_control,
    output logic                        out_done_flag,
    output logic                        busy,
    output logic                        err
);

    localparam int FLUSH_CYCLES = flush_cycles(ARR_HEIGHT, ARR_WIDTH);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] K_MAX_C = CNT_W'(K_MAX);
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FLUSH_CYCLES - 1);

    feeder_state_e    state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [1:0]       simd_q, simd_d;
    logic             err_q, err_d;
    logic             accept;

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign accept  = (state_q == ST_FEED) && s_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            simd_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            simd_q  <= simd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        simd_d  = simd_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    simd_d = cfg_simd;
                    cnt_d  = '0;
                    fcnt_d = '0;
                    if (cfg_k > K_MAX_C) begin
                        k_d   = K_MAX_C;
                        err_d = 1'b1;
                    end else begin
                        k_d   = cfg_k;
                        err_d = 1'b0;
                    end
                    state_d = (cfg_k == '0) ? ST_FLUSH : ST_FEED;
                end
            end
            ST_FEED: begin
                if (s_valid) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == k_q) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = '0;
                    end
                end else begin
`ifdef FEEDER_BUBBLE_EN
                    cnt_d = cnt_q;
`else
                    // A starved stream ends the job early; the flush still runs
                    // so the array sees a clean tail and a done pulse.
                    err_d   = 1'b1;
                    state_d = ST_FLUSH;
                    fcnt_d  = '0;
`endif
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == FC_LAST) state_d = ST_DONE;
                else                   fcnt_d  = fcnt_q + FC_W'(1);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign s_ready       = (state_q == ST_FEED);
    assign out_done_flag = (state_q == ST_DONE);
    assign busy          = (state_q != ST_IDLE);
    assign SIMD_control  = simd_q;
    assign err           = err_q;

    // p0: input capture, zero on every non-accepting cycle
    logic [ARR_HEIGHT*WIDTH-1:0] a_p0;
    logic [ARR_WIDTH*WIDTH-1:0]  b_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_p0 <= '0;
            b_p0 <= '0;
        end else begin
            a_p0 <= accept ? s_a : '0;
            b_p0 <= accept ? s_b : '0;
        end
    end

    // p1..: per-lane diagonal skew
    for (genvar i = 0; i < ARR_HEIGHT; i++) begin : g_lane_a
        skew_delay_line #(.WIDTH(WIDTH), .DEPTH(i)) u_dl (
            .clk   (clk),
            .reset (reset),
            .din   (a_p0[i*WIDTH +: WIDTH]),
            .dout  (out_a[i*WIDTH +: WIDTH])
        );
    end

    for (genvar j = 0; j < ARR_WIDTH; j++) begin : g_lane_b
        skew_delay_line #(.WIDTH(WIDTH), .DEPTH(j)) u_dl (
            .clk   (clk),
            .reset (reset),
            .din   (b_p0[j*WIDTH +: WIDTH]),
            .dout  (out_b[j*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: table-driven jobs, hand sequences
// for reset and skew timing, and randomized jobs against a behavioural model.
module tb_systolic_feeder;

    localparam int WIDTH = 16;
    localparam int H     = 4;
    localparam int W     = 4;
    localparam int K_MAX = 256;
    localparam int CNT_W = $clog2(K_MAX + 1);
    localparam int F     = H + W - 1;
    localparam int MAXC  = 400;
`ifdef FEEDER_BUBBLE_EN
    localparam bit BUBBLE = 1'b1;
`else
    localparam bit BUBBLE = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [CNT_W-1:0]     cfg_k;
    logic [1:0]           cfg_simd;
    logic                 s_valid;
    logic                 s_ready;
    logic [H*WIDTH-1:0]   s_a;
    logic [W*WIDTH-1:0]   s_b;
    logic [H*WIDTH-1:0]   out_a;
    logic [W*WIDTH-1:0]   out_b;
    logic [1:0]           SIMD_control;
    logic                 out_done_flag;
    logic                 busy;
    logic                 err;

    systolic_feeder #(
        .WIDTH(WIDTH), .ARR_HEIGHT(H), .ARR_WIDTH(W), .K_MAX(K_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_k(cfg_k), .cfg_simd(cfg_simd),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .out_a(out_a), .out_b(out_b), .SIMD_control(SIMD_control),
        .out_done_flag(out_done_flag), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit                 vpat [MAXC];
    logic [H*WIDTH-1:0] apat [MAXC];
    logic [W*WIDTH-1:0] bpat [MAXC];
    logic [H*WIDTH-1:0] hist_a [MAXC];
    logic [1:0]         prev_simd;
    bit                 prev_err;

    typedef struct {
        int         k;
        logic [1:0] simd;
        int         bub_at;
        int         bub_len;
        int         noise;
        int         exp_done;
        int         exp_acc;
        bit         exp_err;
    } vec_t;

    task automatic chk(input string name, input int r, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, r, got, exp);
        end
    endtask

    // mode 0: lane value r (A) / 10*r (B) in every lane; mode 1: random
    task automatic fill_pat(input int mode, input int bub_at, input int bub_len);
        for (int r = 0; r < MAXC; r++) begin
            if (mode == 0) begin
                vpat[r] = !(r >= bub_at && r < bub_at + bub_len);
                for (int i = 0; i < H; i++) apat[r][i*WIDTH +: WIDTH] = WIDTH'(r);
                for (int j = 0; j < W; j++) bpat[r][j*WIDTH +: WIDTH] = WIDTH'(10 * r);
            end else begin
                vpat[r] = ($urandom_range(0, 9) != 0);
                for (int i = 0; i < H; i++) apat[r][i*WIDTH +: WIDTH] = WIDTH'($urandom);
                for (int j = 0; j < W; j++) bpat[r][j*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
        end
    endtask

    // Caller sits just after a rising edge. Cycle r=0 carries the start pulse.
    task automatic run_job(input int k, input logic [1:0] simd, input int noise,
                           output int done_rel, output int n_acc, output bit err_end);
        bit acc_v [MAXC];
        bit m_ready [MAXC];
        int keff, cnt, fs, dcyc, rb, src;
        bit e_clamp, m_err;
        logic [H*WIDTH-1:0] ea;
        logic [W*WIDTH-1:0] eb;
        for (int r = 0; r < MAXC; r++) begin
            acc_v[r]   = 1'b0;
            m_ready[r] = 1'b0;
        end
        keff    = (k > K_MAX) ? K_MAX : k;
        e_clamp = (k > K_MAX);
        rb      = -1;
        fs      = -1;
        cnt     = 0;
        if (keff == 0) fs = 1;
        for (int r = 1; r < MAXC - F - 4 && fs < 0; r++) begin
            m_ready[r] = 1'b1;
            if (vpat[r]) begin
                acc_v[r] = 1'b1;
                cnt++;
                if (cnt == keff) fs = r + 1;
            end else if (!BUBBLE) begin
                rb = r;
                fs = r + 1;
            end
        end
        if (fs < 0) fs = MAXC - F - 4;
        dcyc = fs + F;

        done_rel = -1;
        n_acc    = 0;
        err_end  = 1'b0;
        for (int r = 0; r <= dcyc + 2; r++) begin
            if (r == 0) begin
                start    = 1'b1;
                cfg_k    = CNT_W'(k);
                cfg_simd = simd;
            end else begin
                start    = (r <= dcyc) && ((noise == 1) || (noise == 2 && $urandom_range(0, 3) == 0));
                cfg_k    = CNT_W'($urandom_range(0, 300));
                cfg_simd = (noise == 1) ? ~simd : 2'($urandom);
            end
            s_valid = vpat[r];
            s_a     = apat[r];
            s_b     = bpat[r];
            @(negedge clk);
            for (int i = 0; i < H; i++) begin
                src = r - 1 - i;
                ea[i*WIDTH +: WIDTH] = (src >= 1 && acc_v[src]) ? apat[src][i*WIDTH +: WIDTH] : '0;
            end
            for (int j = 0; j < W; j++) begin
                src = r - 1 - j;
                eb[j*WIDTH +: WIDTH] = (src >= 1 && acc_v[src]) ? bpat[src][j*WIDTH +: WIDTH] : '0;
            end
            m_err = (r == 0) ? prev_err : (e_clamp || (rb >= 0 && r > rb));
            chk("s_ready", r, 64'(s_ready), 64'(m_ready[r]));
            chk("busy", r, 64'(busy), 64'(r >= 1 && r <= dcyc));
            chk("done_flag", r, 64'(out_done_flag), 64'(r == dcyc));
            chk("err", r, 64'(err), 64'(m_err));
            chk("simd", r, 64'(SIMD_control), 64'((r == 0) ? prev_simd : simd));
            chk("out_a", r, 64'(out_a), 64'(ea));
            chk("out_b", r, 64'(out_b), 64'(eb));
            hist_a[r] = out_a;
            if (s_valid && s_ready) n_acc++;
            if (out_done_flag && done_rel < 0) begin
                done_rel = r;
                err_end  = err;
            end
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        s_valid   = 1'b0;
        prev_simd = simd;
        prev_err  = e_clamp || (rb >= 0);
    endtask

    initial begin
        vec_t vecs [6];
        int   done_rel, n_acc, k;
        bit   err_end;
        logic [H*WIDTH-1:0] hv;

        vecs[0] = '{k: 3,         simd: 2'd1, bub_at: 0, bub_len: 0, noise: 0, exp_done: 11,  exp_acc: 3,   exp_err: 1'b0};
        vecs[1] = '{k: 0,         simd: 2'd2, bub_at: 0, bub_len: 0, noise: 0, exp_done: 8,   exp_acc: 0,   exp_err: 1'b0};
`ifdef FEEDER_BUBBLE_EN
        vecs[2] = '{k: 3,         simd: 2'd3, bub_at: 2, bub_len: 2, noise: 0, exp_done: 13,  exp_acc: 3,   exp_err: 1'b0};
`else
        vecs[2] = '{k: 3,         simd: 2'd3, bub_at: 2, bub_len: 2, noise: 0, exp_done: 10,  exp_acc: 1,   exp_err: 1'b1};
`endif
        vecs[3] = '{k: 4,         simd: 2'd1, bub_at: 0, bub_len: 0, noise: 1, exp_done: 12,  exp_acc: 4,   exp_err: 1'b0};
        vecs[4] = '{k: K_MAX + 1, simd: 2'd0, bub_at: 0, bub_len: 0, noise: 0, exp_done: 264, exp_acc: 256, exp_err: 1'b1};
        vecs[5] = '{k: 1,         simd: 2'd2, bub_at: 0, bub_len: 0, noise: 0, exp_done: 9,   exp_acc: 1,   exp_err: 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        cfg_k    = '0;
        cfg_simd = '0;
        s_valid  = 1'b0;
        s_a      = '0;
        s_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_a", 0, 64'(out_a), 64'd0);
        chk("rst_out_b", 0, 64'(out_b), 64'd0);
        chk("rst_ctrl", 0, 64'({s_ready, busy, out_done_flag, err, SIMD_control}), 64'd0);
        reset     = 1'b0;
        prev_simd = 2'd0;
        prev_err  = 1'b0;
        @(posedge clk);
        #1;

        for (int t = 0; t < 6; t++) begin
            fill_pat(0, vecs[t].bub_at, vecs[t].bub_len);
            run_job(vecs[t].k, vecs[t].simd, vecs[t].noise, done_rel, n_acc, err_end);
            chk($sformatf("tbl%0d_done_cycle", t), t, 64'(done_rel), 64'(vecs[t].exp_done));
            chk($sformatf("tbl%0d_accepted", t), t, 64'(n_acc), 64'(vecs[t].exp_acc));
            chk($sformatf("tbl%0d_err", t), t, 64'(err_end), 64'(vecs[t].exp_err));
            if (t == 0) begin
                hv = hist_a[1]; chk("skew_a_idle", 1, 64'(hv), 64'd0);
                hv = hist_a[2]; chk("skew_a_l0_first", 2, 64'(hv[15:0]), 64'd1);
                hv = hist_a[4]; chk("skew_a_l0_last", 4, 64'(hv[15:0]), 64'd3);
                hv = hist_a[3]; chk("skew_a_l1_first", 3, 64'(hv[31:16]), 64'd1);
                hv = hist_a[5]; chk("skew_a_l3_first", 5, 64'(hv[63:48]), 64'd1);
                hv = hist_a[7]; chk("skew_a_l3_last", 7, 64'(hv[63:48]), 64'd3);
                hv = hist_a[8]; chk("skew_a_l3_zero", 8, 64'(hv[63:48]), 64'd0);
            end
        end

        // Reset in the middle of FLUSH: everything clears, no done pulse follows.
        start    = 1'b1;
        cfg_k    = CNT_W'(3);
        cfg_simd = 2'd3;
        @(posedge clk);
        #1;
        start   = 1'b0;
        s_valid = 1'b1;
        s_a     = {H{16'h0005}};
        s_b     = {W{16'h0050}};
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_busy", 0, 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("flush_rst_out_a", 0, 64'(out_a), 64'd0);
        chk("flush_rst_out_b", 0, 64'(out_b), 64'd0);
        chk("flush_rst_ctrl", 0, 64'({s_ready, busy, out_done_flag, err, SIMD_control}), 64'd0);
        for (int r = 1; r <= F + 4; r++) begin
            @(negedge clk);
            chk("post_rst_done", r, 64'(out_done_flag), 64'd0);
            chk("post_rst_busy", r, 64'(busy), 64'd0);
            chk("post_rst_out_a", r, 64'(out_a), 64'd0);
        end
        @(posedge clk);
        #1;
        prev_simd = 2'd0;
        prev_err  = 1'b0;

        for (int t = 0; t < 40; t++) begin
            fill_pat(1, 0, 0);
            k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(0, 12));
            run_job(k, 2'($urandom), 2, done_rel, n_acc, err_end);
            chk($sformatf("rnd%0d_done_seen", t), t, 64'(done_rel >= 0), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
